// File: rtl/nand4_bist_checker.sv
// BIST driver/checker for a small NAND/AND cell: sweeps every input
// pattern, samples the cell output after a settle time and logs mismatches.
module nand4_bist_checker #(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter bit EXPECT_AND    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [N_INPUTS-1:0]      dut_in,
  input  logic                     dut_y,
  input  logic                     VPB,
  input  logic                     VPWR,
  input  logic                     VGND,
  input  logic                     VNB,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_INPUTS:0]        err_count,
  output logic [2**N_INPUTS-1:0]   fail_map
);

  localparam int NPAT = 1 << N_INPUTS;
  localparam int SW   = $clog2(SETTLE_CYCLES + 1);

  localparam logic [N_INPUTS:0] LAST_PAT = (N_INPUTS+1)'(NPAT - 1);
  localparam logic [SW-1:0]     SET_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [N_INPUTS:0]   pattern_q, pattern_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic [NPAT-1:0]     map_q, map_d;
  logic                pass_q, pass_d;
  logic                expect_y;
  logic                mismatch;
  logic                active;

  // Power pins only exist for netlist port compatibility.
  logic unused_pwr;
  assign unused_pwr = ^{VPB, VPWR, VGND, VNB};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      settle_q  <= '0;
      err_q     <= '0;
      map_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      settle_q  <= settle_d;
      err_q     <= err_d;
      map_q     <= map_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    settle_d  = settle_q;
    err_d     = err_q;
    map_d     = map_q;
    pass_d    = pass_q;
    expect_y  = EXPECT_AND ? (&pattern_q[N_INPUTS-1:0])
                           : ~(&pattern_q[N_INPUTS-1:0]);
    mismatch  = (dut_y != expect_y);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRIVE;
          pattern_d = '0;
          settle_d  = '0;
          err_d     = '0;
          map_d     = '0;
          pass_d    = 1'b0;
        end
      end
      DRIVE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SET_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          map_d[pattern_q[N_INPUTS-1:0]] = 1'b1;
          err_d = err_q + 1'b1;
        end
        if (pattern_q == LAST_PAT) begin
          state_d = FINISH;
        end else begin
          pattern_d = pattern_q + 1'b1;
          settle_d  = '0;
          state_d   = DRIVE;
        end
      end
      FINISH: begin
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign active    = (state_q == DRIVE) || (state_q == SAMPLE);
  assign dut_in    = active ? pattern_q[N_INPUTS-1:0] : '0;
  assign busy      = active;
  assign done      = (state_q == FINISH);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_map  = map_q;

endmodule

// File: tb/tb_nand4_bist_checker.sv
// Bench for nand4_bist_checker: three instances (default, AND-expect,
// single-settle) with cell models and a done-driven scoreboard.
module tb_nand4_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start0 = 1'b0, start_a = 1'b0, start_s = 1'b0;
  logic [3:0] in0, in_a, in_s;
  logic y0, y_a, y_s;
  logic busy0, done0, pass0, busy_a, done_a, pass_a;
  logic busy_s, done_s, pass_s;
  logic [4:0] err0, err_a, err_s;
  logic [15:0] map0, map_a, map_s;

  int mode = 0;
  int ncyc = 0;
  int checks = 0;
  int failures = 0;

  // Cell models; the delayed ones settle two edges after their input.
  logic d0a = 1'b1, d0b = 1'b1, dsa = 1'b1, dsb = 1'b1;
  always @(posedge clk) begin
    d0a <= ~&in0;
    d0b <= d0a;
    dsa <= ~&in_s;
    dsb <= dsa;
    ncyc <= ncyc + 1;
  end

  always_comb begin
    y0 = ~&in0;
    case (mode)
      1: y0 = 1'b1;
      2: y0 = 1'b0;
      3: y0 = d0b;
      default: ;
    endcase
  end
  assign y_a = ~&in_a;
  assign y_s = dsb;

  nand4_bist_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_in(in0),
    .dut_y(y0), .VPB(1'b1), .VPWR(1'b1), .VGND(1'b0), .VNB(1'b0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_map(map0)
  );

  nand4_bist_checker #(.EXPECT_AND(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(in_a),
    .dut_y(y_a), .VPB(1'b1), .VPWR(1'b1), .VGND(1'b0), .VNB(1'b0),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_map(map_a)
  );

  nand4_bist_checker #(.SETTLE_CYCLES(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .dut_in(in_s),
    .dut_y(y_s), .VPB(1'b1), .VPWR(1'b1), .VGND(1'b0), .VNB(1'b0),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .fail_map(map_s)
  );

  typedef struct {
    logic        pass;
    logic [4:0]  err;
    logic [15:0] map;
    int          lat;
    int          t0;
  } exp_t;

  typedef struct {
    int          mode;
    logic        pass;
    logic [4:0]  err;
    logic [15:0] map;
  } vec_t;

  exp_t q0[$], qa[$], qs[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic res_chk(input string nm, input exp_t e,
                         input logic [4:0] er, input logic [15:0] m);
    chk({nm, " err_count"}, 32'(er), 32'(e.err));
    chk({nm, " fail_map"}, 32'(m), 32'(e.map));
    chk({nm, " done latency"}, 32'(ncyc - e.t0), 32'(e.lat));
  endtask

  // pass is registered in FINISH, so it is checked the cycle after done.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) chk("dut0 unexpected done", 1, 0);
      else begin
        e = q0.pop_front();
        res_chk("dut0", e, err0, map0);
        @(negedge clk);
        chk("dut0 pass", 32'(pass0), 32'(e.pass));
      end
    end
  end

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a) begin
      if (qa.size() == 0) chk("dut_a unexpected done", 1, 0);
      else begin
        e = qa.pop_front();
        res_chk("dut_a", e, err_a, map_a);
        @(negedge clk);
        chk("dut_a pass", 32'(pass_a), 32'(e.pass));
      end
    end
  end

  always @(negedge clk) begin : mon_s
    exp_t e;
    if (done_s) begin
      if (qs.size() == 0) chk("dut_s unexpected done", 1, 0);
      else begin
        e = qs.pop_front();
        res_chk("dut_s", e, err_s, map_s);
        @(negedge clk);
        chk("dut_s pass", 32'(pass_s), 32'(e.pass));
      end
    end
  end

  function automatic int qsize(input int w);
    case (w)
      0: return q0.size();
      1: return qa.size();
      default: return qs.size();
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start0 = v;
      1: start_a = v;
      default: start_s = v;
    endcase
  endtask

  task automatic push(input int w, input exp_t e);
    case (w)
      0: q0.push_back(e);
      1: qa.push_back(e);
      default: qs.push_back(e);
    endcase
  endtask

  task automatic sweep(input int w, input exp_t e);
    @(negedge clk);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    e.t0 = ncyc;
    push(w, e);
  endtask

  task automatic wait_drain(input int w);
    int n = 0;
    while (qsize(w) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (qsize(w) != 0) begin
      chk($sformatf("dut%0d done timeout", w), 32'(qsize(w)), 0);
      case (w)
        0: q0.delete();
        1: qa.delete();
        default: qs.delete();
      endcase
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t tbl[4];
    exp_t e;
    tbl[0] = '{0, 1'b1, 5'd0,  16'h0000};
    tbl[1] = '{1, 1'b0, 5'd1,  16'h8000};
    tbl[2] = '{2, 1'b0, 5'd15, 16'h7FFF};
    tbl[3] = '{3, 1'b1, 5'd0,  16'h0000};

    repeat (3) @(negedge clk);
    chk("reset dut_in", 32'(in0), 0);
    chk("reset busy", 32'(busy0), 0);
    chk("reset done", 32'(done0), 0);
    chk("reset pass", 32'(pass0), 0);
    chk("reset err_count", 32'(err0), 0);
    chk("reset fail_map", 32'(map0), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      e = '{tbl[i].pass, tbl[i].err, tbl[i].map, 48, 0};
      sweep(0, e);
      wait_drain(0);
      chk($sformatf("vec%0d idle hold err", i), 32'(err0), 32'(tbl[i].err));
      chk($sformatf("vec%0d idle busy", i), 32'(busy0), 0);
      chk($sformatf("vec%0d idle dut_in", i), 32'(in0), 0);
    end

    sweep(1, '{1'b0, 5'd16, 16'hFFFF, 48, 0});
    wait_drain(1);

    sweep(2, '{1'b0, 5'd1, 16'h8000, 32, 0});
    wait_drain(2);

    // Held start re-arms on the IDLE cycle right after FINISH.
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    e = '{1'b0, 5'd1, 16'h8000, 32, ncyc};
    qs.push_back(e);
    e.lat = 66;
    qs.push_back(e);
    for (int i = 0; i < 100 && !done_s; i++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10 && !busy_s; i++) @(negedge clk);
    start_s = 1'b0;
    wait_drain(2);

    // A second start mid-sweep must not restart it.
    mode = 0;
    sweep(0, '{1'b1, 5'd0, 16'h0000, 48, 0});
    repeat (3) @(negedge clk);
    chk("mid-sweep dut_in", 32'(in0), 1);
    chk("mid-sweep busy", 32'(busy0), 1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_drain(0);

    // Reset mid-sweep aborts and leaves nothing behind.
    mode = 2;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre-abort err_count", 32'(err0), 6);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort dut_in", 32'(in0), 0);
    chk("abort busy", 32'(busy0), 0);
    chk("abort done", 32'(done0), 0);
    chk("abort pass", 32'(pass0), 0);
    chk("abort err_count", 32'(err0), 0);
    chk("abort fail_map", 32'(map0), 0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("abort stays idle", 32'(busy0), 0);

    mode = 0;
    sweep(0, '{1'b1, 5'd0, 16'h0000, 48, 0});
    wait_drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
